// File: rtl/text_ram_arbiter.sv
// Arbitrates the single-port text RAM between display glyph fetch, the clear engine and the host port.
// Read data comes back two cycles after issue, tagged so display and host reads never collide.
module text_ram_arbiter #(
  parameter int unsigned         COLS   = 80,
  parameter int unsigned         ROWS   = 24,
  parameter int unsigned         ADDR_W = 11,
  parameter int unsigned         DATA_W = 16,
  parameter logic [DATA_W-1:0]   BLANK  = 16'h0720
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_valid_o,
  input  logic              host_valid_i,
  output logic              host_ready_o,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              host_rvalid_o,
  input  logic              clear_start_i,
  output logic              clear_busy_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam int unsigned       CELLS = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(CELLS - 1);

  typedef enum logic {ST_IDLE, ST_FILL} clr_state_t;

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              disp_tag_q, host_tag_q, oor_tag_q;
  logic              disp_valid_q, host_rvalid_q;
  logic [DATA_W-1:0] disp_data_q, host_rdata_q;
  logic              host_fire, host_in_range, clear_grant;

  // Host handshake: a transfer happens in any cycle where host_valid_i and
  // host_ready_o are both high; the host holds its request stable until then.
  assign clear_busy_o  = (state_q == ST_FILL);
  assign host_ready_o  = !disp_req_i && !clear_busy_o && reset_n_i;
  assign host_fire     = host_valid_i && host_ready_o;
  assign host_in_range = (32'(host_addr_i) < CELLS);
  assign clear_grant   = clear_busy_o && !disp_req_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start_i) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end
      end
      ST_FILL: begin
        // Counter only advances on cycles the display did not steal.
        if (clear_grant) begin
          if (cnt_q == LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (disp_req_i) begin
      ram_en_o   = 1'b1;
      ram_addr_o = disp_addr_i;
    end else if (clear_busy_o) begin
      ram_en_o    = 1'b1;
      ram_we_o    = 1'b1;
      ram_addr_o  = cnt_q;
      ram_wdata_o = BLANK;
    end else if (host_fire) begin
      ram_en_o    = host_in_range;
      ram_we_o    = host_we_i && host_in_range;
      ram_addr_o  = host_addr_i;
      ram_wdata_o = host_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      disp_tag_q    <= 1'b0;
      host_tag_q    <= 1'b0;
      oor_tag_q     <= 1'b0;
      disp_valid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      disp_data_q   <= BLANK;
      host_rdata_q  <= BLANK;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      disp_tag_q    <= disp_req_i;
      host_tag_q    <= host_fire && !host_we_i && host_in_range;
      oor_tag_q     <= host_fire && !host_we_i && !host_in_range;
      disp_valid_q  <= disp_tag_q;
      host_rvalid_q <= host_tag_q || oor_tag_q;
      if (disp_tag_q) disp_data_q <= ram_rdata_i;
      // Out-of-range reads never touched the RAM, so they return BLANK instead.
      if (host_tag_q)     host_rdata_q <= ram_rdata_i;
      else if (oor_tag_q) host_rdata_q <= BLANK;
    end
  end

  assign disp_data_o   = disp_data_q;
  assign disp_valid_o  = disp_valid_q;
  assign host_rdata_o  = host_rdata_q;
  assign host_rvalid_o = host_rvalid_q;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Directed bench for text_ram_arbiter with a behavioural single-port RAM and write-count scoreboard.
module tb_text_ram_arbiter;

  localparam logic [15:0] BLANK = 16'h0720;
  localparam int          CELLS = 1920;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        disp_req;
  logic [10:0] disp_addr;
  logic [15:0] disp_data;
  logic        disp_valid;
  logic        host_valid;
  logic        host_ready;
  logic        host_we;
  logic [10:0] host_addr;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        host_rvalid;
  logic        clear_start;
  logic        clear_busy;
  logic        ram_en;
  logic        ram_we;
  logic [10:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  text_ram_arbiter dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .disp_req_i    (disp_req),
    .disp_addr_i   (disp_addr),
    .disp_data_o   (disp_data),
    .disp_valid_o  (disp_valid),
    .host_valid_i  (host_valid),
    .host_ready_o  (host_ready),
    .host_we_i     (host_we),
    .host_addr_i   (host_addr),
    .host_wdata_i  (host_wdata),
    .host_rdata_o  (host_rdata),
    .host_rvalid_o (host_rvalid),
    .clear_start_i (clear_start),
    .clear_busy_o  (clear_busy),
    .ram_en_o      (ram_en),
    .ram_we_o      (ram_we),
    .ram_addr_o    (ram_addr),
    .ram_wdata_o   (ram_wdata),
    .ram_rdata_i   (ram_rdata)
  );

  // Single-port RAM model plus per-address write counter for the clear check.
  logic [15:0] mem [0:2047];
  int          wr_cnt [0:2047];
  int          bad_wdata = 0;
  logic        cnt_clr  = 1'b0;
  logic        count_en = 1'b0;

  always @(posedge clk) begin
    if (cnt_clr) begin
      for (int i = 0; i < 2048; i++) wr_cnt[i] <= 0;
      bad_wdata <= 0;
    end else if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        if (count_en) begin
          wr_cnt[ram_addr] <= wr_cnt[ram_addr] + 1;
          if (ram_wdata != BLANK) bad_wdata <= bad_wdata + 1;
        end
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks run 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int k, busy, taken, hr_seen, bad, seen;
  logic [10:0] last_addr;

  initial begin
    reset_n = 1'b0; disp_req = 1'b0; disp_addr = '0; host_valid = 1'b0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0; clear_start = 1'b0;
    repeat (3) step();
    reset_n = 1'b1; #1;
    check("rst_host_ready", host_ready, 1);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_host_rvalid", host_rvalid, 0);
    check("rst_clear_busy", clear_busy, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_disp_data", disp_data, BLANK);
    check("rst_host_rdata", host_rdata, BLANK);

    // Host write then read of address 5.
    step();
    host_valid = 1'b1; host_we = 1'b1; host_addr = 11'd5; host_wdata = 16'h1241; #1;
    check("wr_ready", host_ready, 1);
    check("wr_ram_en", ram_en, 1);
    check("wr_ram_we", ram_we, 1);
    check("wr_ram_addr", ram_addr, 5);
    check("wr_ram_wdata", ram_wdata, 16'h1241);
    step();
    host_we = 1'b0; #1;
    check("rd_ram_en", ram_en, 1);
    check("rd_ram_we", ram_we, 0);
    check("rd_ram_addr", ram_addr, 5);
    step();
    host_valid = 1'b0; #1;
    check("rd_rvalid_t2", host_rvalid, 0);
    step(); #1;
    check("rd_rvalid_t3", host_rvalid, 1);
    check("rd_rdata", host_rdata, 16'h1241);
    step(); #1;
    check("rd_rvalid_t4", host_rvalid, 0);

    // Preload address 100, then display read colliding with a host write.
    host_valid = 1'b1; host_we = 1'b1; host_addr = 11'd100; host_wdata = 16'hABCD;
    step();
    host_valid = 1'b0;
    step();
    disp_req = 1'b1; disp_addr = 11'd100;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 11'd7; host_wdata = 16'h2222; #1;
    check("col_host_ready", host_ready, 0);
    check("col_ram_en", ram_en, 1);
    check("col_ram_we", ram_we, 0);
    check("col_ram_addr", ram_addr, 100);
    step();
    disp_req = 1'b0; #1;
    check("col_host_ready_c1", host_ready, 1);
    check("col_host_we_c1", ram_we, 1);
    check("col_host_addr_c1", ram_addr, 7);
    check("col_host_wdata_c1", ram_wdata, 16'h2222);
    step();
    host_valid = 1'b0; #1;
    check("col_disp_valid", disp_valid, 1);
    check("col_disp_data", disp_data, 16'hABCD);
    step(); #1;
    check("col_disp_valid_off", disp_valid, 0);

    // Display read then host read in back-to-back cycles.
    disp_req = 1'b1; disp_addr = 11'd100;
    step();
    disp_req = 1'b0; host_valid = 1'b1; host_we = 1'b0; host_addr = 11'd7;
    step();
    host_valid = 1'b0; #1;
    check("b2b_disp_valid", disp_valid, 1);
    check("b2b_disp_data", disp_data, 16'hABCD);
    check("b2b_host_rvalid_early", host_rvalid, 0);
    step(); #1;
    check("b2b_host_rvalid", host_rvalid, 1);
    check("b2b_host_rdata", host_rdata, 16'h2222);
    check("b2b_disp_valid_off", disp_valid, 0);

    // Out-of-range host read.
    step();
    host_valid = 1'b1; host_we = 1'b0; host_addr = 11'd1920; #1;
    check("oor_ram_en", ram_en, 0);
    check("oor_ready", host_ready, 1);
    step();
    host_valid = 1'b0; #1;
    check("oor_rvalid_t1", host_rvalid, 0);
    step(); #1;
    check("oor_rvalid_t2", host_rvalid, 1);
    check("oor_rdata", host_rdata, BLANK);

    // Full clear with a display slot every 10 cycles and a host write in the start cycle.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    clear_start = 1'b1; host_valid = 1'b1; host_we = 1'b1; host_addr = 11'd9; host_wdata = 16'h5555; #1;
    check("clr_start_host_ready", host_ready, 1);
    check("clr_start_host_addr", ram_addr, 9);
    check("clr_start_host_we", ram_we, 1);
    step();
    clear_start = 1'b0; host_valid = 1'b0; count_en = 1'b1; #1;
    check("clr_busy_on", clear_busy, 1);
    k = 0; busy = 0; taken = 0; hr_seen = 0; last_addr = '0;
    while (clear_busy && k < 3000) begin
      disp_req = (k % 10 == 0); disp_addr = 11'(k % CELLS); clear_start = (k == 700); #1;
      if (host_ready) hr_seen++;
      if (!disp_req) last_addr = ram_addr;
      busy++;
      if (disp_req) taken++;
      step();
      k++;
    end
    disp_req = 1'b0; clear_start = 1'b0; count_en = 1'b0; #1;
    check("clr_busy_cycles", busy, CELLS + taken);
    check("clr_host_blocked", hr_seen, 0);
    check("clr_last_addr", last_addr, 1919);
    check("clr_busy_off", clear_busy, 0);
    check("clr_host_ready_after", host_ready, 1);
    bad = 0;
    for (int i = 0; i < CELLS; i++) if (wr_cnt[i] != 1 || mem[i] != BLANK) bad++;
    check("clr_cells_once_blank", bad, 0);
    check("clr_wdata_blank", bad_wdata, 0);

    // Reset in the middle of a clear, at counter 500.
    step();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (500) step();
    #1;
    check("mid_clr_addr", ram_addr, 500);
    check("mid_clr_we", ram_we, 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1; #1;
    check("mid_clr_rst_busy", clear_busy, 0);
    check("mid_clr_rst_ram_en", ram_en, 0);

    // Reset while a host read is in flight.
    host_valid = 1'b1; host_we = 1'b0; host_addr = 11'd7;
    step();
    host_valid = 1'b0; reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    seen = 0;
    repeat (4) begin
      #1;
      if (host_rvalid) seen++;
      step();
    end
    check("rst_rd_no_rvalid", seen, 0);
    check("rst_rd_rdata", host_rdata, BLANK);

    // A fresh clear restarts from address 0.
    clear_start = 1'b1;
    step();
    clear_start = 1'b0; #1;
    check("restart_busy", clear_busy, 1);
    check("restart_addr", ram_addr, 0);
    check("restart_we", ram_we, 1);
    k = 0;
    while (clear_busy && k < 2500) begin
      step();
      k++;
    end
    #1;
    check("restart_done", clear_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/text_ram_arbiter.md
Name: text_ram_arbiter

Overview:
- Shares the single-port text buffer (character + attribute per cell) between three requesters:
  - VGA glyph fetch, which is hard real-time and has absolute priority.
  - A built-in clear-screen engine.
  - The terminal host write/read port.
- Sits between the VGA timing/glyph pipeline and the text RAM.
- Issues at most one RAM operation per clock and routes read data back to the issuer.

Parameters:
- COLS, 80, glyph columns per row.
- ROWS, 24, glyph rows per screen.
- ADDR_W, 11, text RAM address width; must satisfy 2^ADDR_W >= COLS*ROWS.
- DATA_W, 16, cell width: [7:0] char, [15:8] attribute.
- BLANK, 16'h0720, value written by clear and returned for out-of-range host reads.

Ports:
- clk  in  1  system pixel clock.
- reset_n  in  1  synchronous, active-low reset.
- disp_req  in  1  display read request, single-cycle pulse, at most one per 10 clocks.
- disp_addr  in  ADDR_W  display cell address, valid with disp_req.
- disp_data  out  DATA_W  display read data.
- disp_valid  out  1  one-cycle pulse, disp_data valid.
- host_valid  in  1  host request valid.
- host_ready  out  1  host request accepted this cycle when high with host_valid.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host cell address.
- host_wdata  in  DATA_W  host write data.
- host_rdata  out  DATA_W  host read data.
- host_rvalid  out  1  one-cycle pulse, host_rdata valid.
- clear_start  in  1  pulse: fill the whole screen with BLANK.
- clear_busy  out  1  clear engine running.
- ram_en  out  1  RAM access this cycle.
- ram_we  out  1  RAM write.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, one cycle after the read.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - disp_valid, host_rvalid, clear_busy, read tags, clear counter: all 0.
  - disp_data, host_rdata: BLANK.
  - Any clear in progress is aborted and any in-flight read is discarded (no rvalid).
- Arbitration, each cycle, priority order:
  1. disp_req: display read.
  2. clear_busy: clear write.
  3. host transfer.
- RAM outputs are combinational from the grant:
  - Display: ram_en=1, ram_we=0, ram_addr=disp_addr.
  - Clear: ram_en=1, ram_we=1, ram_addr=clear counter, ram_wdata=BLANK.
  - Host: ram_en=1, ram_we=host_we, ram_addr=host_addr, ram_wdata=host_wdata.
  - Idle: ram_en=0, ram_we=0.
- host_ready = !disp_req && !clear_busy && reset_n. A transfer occurs when host_valid && host_ready. Host must hold its request stable until accepted.
- Host address range:
  - host_addr >= COLS*ROWS is accepted but makes no RAM access (ram_en=0).
  - An out-of-range read still returns BLANK with normal latency.
- Read latency:
  - Read issued in cycle T: a registered tag (display / host / host-OOR) is set in T.
  - In T+1, ram_rdata (or BLANK for OOR) is captured into the tagged output register.
  - The matching valid pulse is high in T+2 for exactly one cycle.
  - Data registers hold their value until the next capture.
- Display and host reads in back-to-back cycles each return independently: separate tags, no collision.
- Clear engine, states IDLE and FILL:
  - IDLE: clear_start=1 → FILL, counter=0, clear_busy=1 from next cycle.
  - FILL: write counter each cycle not taken by disp_req. Counter increments only on a granted write.
  - After writing address COLS*ROWS-1 → IDLE; clear_busy low the following cycle.
  - clear_start while FILL is ignored and does not restart.
  - clear_start coinciding with a host request: clear wins from the next cycle on. The host request in that same cycle is still accepted, because host_ready depends on registered clear_busy.
- disp_addr is not range-checked; the display side guarantees it.
- Display never stalls. Host gets at least 9 of every 10 cycles when clear is idle.

Test Plan:
- Reset → host_ready=1, all valids 0, clear_busy=0, ram_en=0, disp_data=host_data=16'h0720.
- Host write addr 5 data 16'h1241, then host read addr 5 → ram_we=1 in cycle 0; read issued cycle 1; host_rvalid cycle 3 with host_rdata=16'h1241.
- disp_req addr 100 with host_valid write addr 7 in the same cycle:
  - Cycle 0: host_ready=0, RAM addr 100 read.
  - Host write granted cycle 1.
  - disp_valid cycle 2 with RAM content.
- clear_start with disp_req every 10 cycles:
  - clear_busy high for 1920 + number of display slots taken.
  - All 1920 addresses written 16'h0720 exactly once.
  - host_ready=0 throughout; busy drops after address 1919.
- Host read addr 1920 (out of range) → ram_en=0, host_rvalid 2 cycles later, host_rdata=16'h0720.
- reset_n low mid-clear at counter 500 and mid host read → clear_busy=0, no host_rvalid; new clear_start restarts from address 0.
